// File: rtl/if_mem_ctrl_pkg.sv
// Shared definitions for the instruction-fetch memory controller: bus widths,
// the all-zero word, fetch FSM encodings and a byte-lane insert helper.
package if_mem_ctrl_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_e;

    function automatic logic [InstBus-1:0] put_byte(
        input logic [InstBus-1:0] word,
        input logic [1:0]         lane,
        input logic [7:0]         data
    );
        logic [InstBus-1:0] r;
        r = word;
        r[{lane, 3'b000} +: 8] = data;
        return r;
    endfunction

endpackage

// File: rtl/if_mem_ctrl_if.sv
// Fetch-stage and byte-wide RAM port signals of if_mem_ctrl; the slave
// modport is the controller's view, master is the fetch stage / RAM side.
interface if_mem_ctrl_if;
    import if_mem_ctrl_pkg::*;

    logic                   req_i;
    logic [InstAddrBus-1:0] pc_i;
    logic                   flush_i;
    logic                   mem_busy_i;
    logic [7:0]             mem_din_i;
    logic [InstAddrBus-1:0] mem_a_o;
    logic                   mem_wr_o;
    logic [InstBus-1:0]     inst_o;
    logic                   pc_done_o;

    modport slave (
        input  req_i, pc_i, flush_i, mem_busy_i, mem_din_i,
        output mem_a_o, mem_wr_o, inst_o, pc_done_o
    );

    modport master (
        output req_i, pc_i, flush_i, mem_busy_i, mem_din_i,
        input  mem_a_o, mem_wr_o, inst_o, pc_done_o
    );

endinterface

// File: rtl/if_mem_ctrl_icache.sv
// Direct-mapped instruction cache of 32-bit words with a registered lookup;
// only instantiated by if_mem_ctrl when ICACHE_EN is defined.
module if_mem_ctrl_icache import if_mem_ctrl_pkg::*; #(
    parameter int LINES = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lookup_i,
    input  logic [15:0]        lookup_word_i,
    output logic               hit_o,
    output logic [InstBus-1:0] data_o,
    input  logic               fill_i,
    input  logic [15:0]        fill_word_i,
    input  logic [InstBus-1:0] fill_data_i
);

    localparam int IdxW = $clog2(LINES);
    localparam int TagW = 16 - IdxW;

    logic [LINES-1:0]   valid_q;
    logic [TagW-1:0]    tag_mem [LINES];
    logic [InstBus-1:0] data_mem [LINES];
    logic               hit_q;
    logic [InstBus-1:0] rd_q;

    logic [IdxW-1:0] lk_idx_s;
    logic [TagW-1:0] lk_tag_s;
    logic [IdxW-1:0] fl_idx_s;
    logic [TagW-1:0] fl_tag_s;

    assign lk_idx_s = lookup_word_i[IdxW-1:0];
    assign lk_tag_s = lookup_word_i[15:IdxW];
    assign fl_idx_s = fill_word_i[IdxW-1:0];
    assign fl_tag_s = fill_word_i[15:IdxW];

    // Valid bits and the one-cycle lookup result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= {LINES{1'b0}};
            hit_q   <= 1'b0;
            rd_q    <= ZeroWord;
        end else begin
            if (fill_i) begin
                valid_q[fl_idx_s] <= 1'b1;
            end else begin
                valid_q <= valid_q;
            end
            hit_q <= lookup_i && valid_q[lk_idx_s] && (tag_mem[lk_idx_s] == lk_tag_s);
            rd_q  <= data_mem[lk_idx_s];
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_mem[fl_idx_s]  <= fl_tag_s;
            data_mem[fl_idx_s] <= fill_data_i;
        end
    end

    assign hit_o  = hit_q;
    assign data_o = rd_q;

endmodule

// File: rtl/if_mem_ctrl.sv
// Instruction-fetch controller: assembles a 32-bit word from four byte reads.
// Optional instruction cache enabled by defining the macro ICACHE_EN.
module if_mem_ctrl import if_mem_ctrl_pkg::*; #(
    parameter int ICACHE_LINES = 128
) (
    input logic          clk,
    input logic          rst,
    if_mem_ctrl_if.slave bus
);

    if (ICACHE_LINES < 2 || ICACHE_LINES > 65536 ||
        (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_lines_check
        $error("ICACHE_LINES must be a power of two between 2 and 65536");
    end

    fetch_state_e state_q, state_d;

    logic [InstAddrBus-1:0] fpc_q, fpc_d;
    logic [2:0]             issue_q, issue_d;
    logic [2:0]             recv_q, recv_d;
    logic                   inflight_q, inflight_d;
    logic                   pend_q, pend_d;
    logic [InstBus-1:0]     buf_q, buf_d;
    logic [InstBus-1:0]     inst_q, inst_d;
    logic [InstAddrBus-1:0] mem_a_q, mem_a_d;
    logic                   pc_done_q, pc_done_d;

    logic               accept_s;
    logic               issue_go_s;
    logic               capture_s;
    logic               last_byte_s;
    logic               hit_s;
    logic [InstBus-1:0] hit_data_s;

    assign accept_s    = (state_q == ST_IDLE) && bus.req_i && !bus.flush_i;
    assign issue_go_s  = (state_q == ST_FETCH) && !bus.flush_i && !bus.mem_busy_i &&
                         (issue_q < 3'd4) && !hit_s;
    assign capture_s   = (state_q == ST_FETCH) && !bus.flush_i && pend_q;
    assign last_byte_s = capture_s && (recv_q == 3'd3);

`ifdef ICACHE_EN
    // Lookup happens on the accepting edge; the hit is seen in the first FETCH cycle.
    if_mem_ctrl_icache #(
        .LINES(ICACHE_LINES)
    ) u_icache (
        .clk          (clk),
        .rst          (rst),
        .lookup_i     (accept_s),
        .lookup_word_i(bus.pc_i[17:2]),
        .hit_o        (hit_s),
        .data_o       (hit_data_s),
        .fill_i       (last_byte_s),
        .fill_word_i  (fpc_q[17:2]),
        .fill_data_i  (buf_d)
    );
`else
    assign hit_s      = 1'b0;
    assign hit_data_s = ZeroWord;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush always wins and returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.flush_i) begin
                    state_d = ST_IDLE;
                end else if (hit_s || last_byte_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        fpc_d      = fpc_q;
        issue_d    = issue_q;
        recv_d     = recv_q;
        buf_d      = buf_q;
        inst_d     = inst_q;
        mem_a_d    = mem_a_q;
        inflight_d = issue_go_s;
        pend_d     = inflight_q && !bus.flush_i;
        pc_done_d  = 1'b0;

        if (accept_s) begin
            fpc_d   = bus.pc_i;
            issue_d = 3'd0;
            recv_d  = 3'd0;
            buf_d   = ZeroWord;
        end else begin
            fpc_d = fpc_q;
        end

        if (issue_go_s) begin
            mem_a_d = fpc_q + {29'd0, issue_q};
            issue_d = issue_q + 3'd1;
        end else begin
            mem_a_d = mem_a_q;
        end

        if (capture_s) begin
            buf_d  = put_byte(buf_q, recv_q[1:0], bus.mem_din_i);
            recv_d = recv_q + 3'd1;
        end else begin
            recv_d = recv_d;
        end

        // inst_o only changes on the edge that enters DONE.
        if ((state_q == ST_FETCH) && (state_d == ST_DONE)) begin
            pc_done_d = 1'b1;
            inst_d    = hit_s ? hit_data_s : buf_d;
        end else begin
            pc_done_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q      <= ZeroWord;
            issue_q    <= 3'd0;
            recv_q     <= 3'd0;
            inflight_q <= 1'b0;
            pend_q     <= 1'b0;
            buf_q      <= ZeroWord;
            inst_q     <= ZeroWord;
            mem_a_q    <= ZeroWord;
            pc_done_q  <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            issue_q    <= issue_d;
            recv_q     <= recv_d;
            inflight_q <= inflight_d;
            pend_q     <= pend_d;
            buf_q      <= buf_d;
            inst_q     <= inst_d;
            mem_a_q    <= mem_a_d;
            pc_done_q  <= pc_done_d;
        end
    end

    assign bus.mem_a_o   = mem_a_q;
    assign bus.mem_wr_o  = 1'b0;
    assign bus.inst_o    = inst_q;
    assign bus.pc_done_o = pc_done_q;

endmodule

// File: tb/tb_if_mem_ctrl.sv
// Scoreboard bench for if_mem_ctrl: stimulus pushes expected addresses and
// completions keyed by cycle; a negedge monitor pops and compares them.
module tb_if_mem_ctrl;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t addr_q[$];
    exp_t done_q[$];

    int          hold_cyc;
    logic [31:0] hold_val;
    logic [31:0] a_hold;

    if_mem_ctrl_if bus();

    if_mem_ctrl #(.ICACHE_LINES(128)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'h13;
            32'h0000_0101: return 8'h05;
            32'h0000_0102: return 8'h10;
            32'h0000_0103: return 8'h00;
            32'h0000_0200: return 8'h93;
            32'h0000_0201: return 8'h00;
            32'h0000_0202: return 8'h50;
            32'h0000_0203: return 8'h00;
            32'h0000_0300: return 8'h13;
            32'h0000_0301: return 8'h01;
            32'h0000_0302: return 8'h70;
            32'h0000_0303: return 8'h00;
            32'hFFFF_FFFC: return 8'hB7;
            32'hFFFF_FFFD: return 8'h40;
            32'hFFFF_FFFE: return 8'h34;
            32'hFFFF_FFFF: return 8'h12;
            default:       return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // RAM model: the byte for an address appears one cycle after that address.
    always @(negedge clk) begin
        bus.mem_din_i = ram_rd(a_hold);
        a_hold        = bus.mem_a_o;
    end

    // Monitor: compares RAM addresses and completions against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (addr_q.size() > 0 && addr_q[0].cyc <= cyc) begin
                checks = checks + 1;
                if (addr_q[0].cyc != cyc || bus.mem_a_o !== addr_q[0].val) begin
                    errors = errors + 1;
                    $display("FAIL mem_a_o @%0d: got %h expected %h (due @%0d)",
                             cyc, bus.mem_a_o, addr_q[0].val, addr_q[0].cyc);
                end
                void'(addr_q.pop_front());
            end
            if (bus.pc_done_o === 1'b1) begin
                checks = checks + 1;
                if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
                    if (bus.inst_o !== done_q[0].val) begin
                        errors = errors + 1;
                        $display("FAIL inst_o @%0d: got %h expected %h",
                                 cyc, bus.inst_o, done_q[0].val);
                    end
                    hold_cyc = cyc + 1;
                    hold_val = done_q[0].val;
                    void'(done_q.pop_front());
                end else begin
                    errors = errors + 1;
                    $display("FAIL pc_done_o @%0d: got 1 expected 0 (unexpected completion)", cyc);
                end
            end else if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL pc_done_o @%0d: got 0 expected 1 (inst %h)", cyc, done_q[0].val);
                void'(done_q.pop_front());
            end
            if (hold_cyc == cyc) begin
                checks = checks + 1;
                if (bus.inst_o !== hold_val) begin
                    errors = errors + 1;
                    $display("FAIL inst_hold @%0d: got %h expected %h", cyc, bus.inst_o, hold_val);
                end
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full miss fetch; stall>0 holds mem_busy_i for that many cycles after the second issue.
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] inst, input int stall);
        int c0;
        @(negedge clk);
        c0 = cyc;
        bus.req_i = 1'b1;
        bus.pc_i  = pc;
        addr_q.push_back('{cyc: c0 + 2, val: pc});
        addr_q.push_back('{cyc: c0 + 3, val: pc + 32'd1});
        addr_q.push_back('{cyc: c0 + 4 + stall, val: pc + 32'd2});
        addr_q.push_back('{cyc: c0 + 5 + stall, val: pc + 32'd3});
        done_q.push_back('{cyc: c0 + 7 + stall, val: inst});
        @(negedge clk);
        bus.req_i = 1'b0;
        bus.pc_i  = 32'hDEAD_BEEF;
        if (stall > 0) begin
            repeat (2) @(negedge clk);
            bus.mem_busy_i = 1'b1;
            repeat (stall) @(negedge clk);
            bus.mem_busy_i = 1'b0;
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int c0;
        cyc            = 0;
        checks         = 0;
        errors         = 0;
        hold_cyc       = -1;
        hold_val       = 32'h0000_0000;
        a_hold         = 32'h0000_0000;
        rst            = 1'b1;
        bus.req_i      = 1'b0;
        bus.pc_i       = 32'h0000_0000;
        bus.flush_i    = 1'b0;
        bus.mem_busy_i = 1'b0;
        bus.mem_din_i  = 8'h00;

        @(negedge clk);
        check32("reset pc_done_o", {31'd0, bus.pc_done_o}, 32'd0);
        check32("reset inst_o", bus.inst_o, 32'h0000_0000);
        check32("reset mem_a_o", bus.mem_a_o, 32'h0000_0000);
        check32("reset mem_wr_o", {31'd0, bus.mem_wr_o}, 32'd0);
        rst = 1'b0;

        do_fetch(32'h0000_0100, 32'h0010_0513, 0);
        do_fetch(32'hFFFF_FFFC, 32'h1234_40B7, 0);
        do_fetch(32'h0000_0300, 32'h0070_0113, 2);

        // Flush after two issues: no completion, address must not advance.
        @(negedge clk);
        c0 = cyc;
        bus.req_i = 1'b1;
        bus.pc_i  = 32'h0000_0200;
        addr_q.push_back('{cyc: c0 + 2, val: 32'h0000_0200});
        addr_q.push_back('{cyc: c0 + 3, val: 32'h0000_0201});
        addr_q.push_back('{cyc: c0 + 4, val: 32'h0000_0201});
        @(negedge clk);
        bus.req_i = 1'b0;
        repeat (2) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        do_fetch(32'h0000_0100, 32'h0010_0513, 0);

        // Reset in the middle of a fetch.
        @(negedge clk);
        c0 = cyc;
        bus.req_i = 1'b1;
        bus.pc_i  = 32'h0000_0200;
        addr_q.push_back('{cyc: c0 + 2, val: 32'h0000_0200});
        addr_q.push_back('{cyc: c0 + 3, val: 32'h0000_0201});
        @(negedge clk);
        bus.req_i = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check32("midrst pc_done_o", {31'd0, bus.pc_done_o}, 32'd0);
        check32("midrst inst_o", bus.inst_o, 32'h0000_0000);
        check32("midrst mem_a_o", bus.mem_a_o, 32'h0000_0000);
        check32("midrst mem_wr_o", {31'd0, bus.mem_wr_o}, 32'd0);
        rst = 1'b0;
        do_fetch(32'h0000_0200, 32'h0050_0093, 0);

`ifdef ICACHE_EN
        // Hit: completion one cycle after sampling, RAM address untouched.
        @(negedge clk);
        c0 = cyc;
        bus.req_i = 1'b1;
        bus.pc_i  = 32'h0000_0200;
        done_q.push_back('{cyc: c0 + 2, val: 32'h0050_0093});
        addr_q.push_back('{cyc: c0 + 2, val: 32'h0000_0203});
        addr_q.push_back('{cyc: c0 + 3, val: 32'h0000_0203});
        addr_q.push_back('{cyc: c0 + 5, val: 32'h0000_0203});
        @(negedge clk);
        bus.req_i = 1'b0;
        repeat (8) @(negedge clk);
        do_fetch(32'h0000_0400, 32'hA6A7_A4A5, 0);
        do_fetch(32'h0000_0200, 32'h0050_0093, 0);
`endif

        repeat (4) @(negedge clk);
        checks = checks + 1;
        if (addr_q.size() != 0 || done_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: got %0d addr and %0d done left expected 0",
                     addr_q.size(), done_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
